// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier sequencer.
// No logic; latency and backpressure are defined by the modules that import it.
package mult_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_TIMEOUT  = 255;
  localparam int GUARD_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    GUARD,
    HALT
  } state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Two-entry operand queue; head visible combinationally, push/pop take effect at the edge.
// Backpressure: full blocks push, empty blocks pop; simultaneous push and pop both apply.
module mult_op_fifo #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head_dat,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Feeds queued operand pairs one at a time to an external radix-4 multiplier and returns products.
// Latency: ISSUE + multiplier + 1 to out_valid; one result outstanding, issue held while it is unconsumed.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               err,
  output logic               busy,
  output logic               mul_bgn,
  output logic [WIDTH-1:0]   mul_ibusA,
  output logic [WIDTH-1:0]   mul_ibusB,
  input  logic [WIDTH-1:0]   mul_obusA,
  input  logic [WIDTH-1:0]   mul_obusB,
  input  logic               mul_fin
);

  localparam int             CW   = $clog2(TIMEOUT + 1);
  localparam int             GW   = $clog2(GUARD_CYCLES + 1);
  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0]  GMAX = GW'(GUARD_CYCLES - 1);

  state_t               state;
  logic [CW-1:0]        wait_cnt;
  logic [GW-1:0]        guard_cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [2*WIDTH-1:0]   fifo_head;
  logic                 can_issue;

  // A new job only starts once the previous result has left or is leaving this cycle.
  assign can_issue = !fifo_empty && (!out_valid || out_ready);
  assign fifo_pop  = (state == IDLE) && can_issue;
  assign in_ready  = !fifo_full && (state != HALT);
  assign busy      = (state != IDLE);

  mult_op_fifo #(
    .DW (2 * WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid && in_ready),
    .push_dat ({in_a, in_b}),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      guard_cnt <= '0;
      mul_bgn   <= 1'b0;
      mul_ibusA <= '0;
      mul_ibusB <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      err       <= 1'b0;
    end else begin
      mul_bgn <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (can_issue) begin
            {mul_ibusA, mul_ibusB} <= fifo_head;
            mul_bgn                <= 1'b1;
            state                  <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // A fin on the last allowed cycle still counts as a completion.
          if (mul_fin) begin
            out_prod  <= {mul_obusA, mul_obusB};
            out_valid <= 1'b1;
            guard_cnt <= '0;
            state     <= GUARD;
          end else if (wait_cnt == TMAX) begin
            err   <= 1'b1;
            state <= HALT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        GUARD: begin
          if (guard_cnt == GMAX) begin
            state <= IDLE;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: table vectors, stall/timeout/reset sequences, random jobs vs a queue model.
module tb_mult_sequencer;

  localparam int W  = 32;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_prod;
  logic          err;
  logic          busy;
  logic          mul_bgn;
  logic [W-1:0]  mul_ibusA;
  logic [W-1:0]  mul_ibusB;
  logic [W-1:0]  mul_obusA;
  logic [W-1:0]  mul_obusB;
  logic          mul_fin;

  always #5 clk = ~clk;

  mult_sequencer #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .err       (err),
    .busy      (busy),
    .mul_bgn   (mul_bgn),
    .mul_ibusA (mul_ibusA),
    .mul_ibusB (mul_ibusB),
    .mul_obusA (mul_obusA),
    .mul_obusB (mul_obusB),
    .mul_fin   (mul_fin)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    logic [63:0]  prod;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  int          out_count = 0;
  int          bgn_count = 0;
  int          cyc = 0;
  int          last_fin_cyc = -100;
  int          model_en = 1;
  int          lat_rand = 0;
  int          fin_lat = 3;
  int          inject_req = 0;
  int          inject_done = 0;
  int          m_cnt = 0;
  logic [63:0] m_prod;
  logic        stall_prev = 1'b0;
  logic [63:0] held;

  function automatic logic [63:0] ref_mul(logic [W-1:0] a, logic [W-1:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    return sa * sb;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // One clock: observe handshakes mid-cycle, then play the multiplier just after the edge.
  task automatic step();
    logic         s_bgn;
    logic [W-1:0] s_a;
    logic [W-1:0] s_b;
    int           lat;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("valid_hold", 64'(out_valid), 64'd1);
        check("prod_hold", out_prod, held);
      end
      if (in_valid && in_ready) exp_q.push_back(ref_mul(in_a, in_b));
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) check("unexpected_out", out_prod, 64'hx);
        else check("prod_order", out_prod, exp_q.pop_front());
      end
      stall_prev = out_valid && !out_ready;
      held       = out_prod;
    end
    s_bgn = mul_bgn;
    s_a   = mul_ibusA;
    s_b   = mul_ibusB;
    if (s_bgn) begin
      bgn_count++;
      check("bgn_spacing", 64'(cyc - last_fin_cyc >= 4), 64'd1);
    end
    @(posedge clk);
    #1;
    cyc++;
    mul_fin   = 1'b0;
    mul_obusA = $urandom;
    mul_obusB = $urandom;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        mul_fin = 1'b1;
        {mul_obusA, mul_obusB} = m_prod;
      end
    end
    if (s_bgn && model_en != 0) begin
      m_prod = ref_mul(s_a, s_b);
      lat    = (lat_rand != 0) ? int'($urandom_range(1, 8)) : fin_lat;
      if (lat <= 1) begin
        mul_fin = 1'b1;
        {mul_obusA, mul_obusB} = m_prod;
      end else begin
        m_cnt = lat - 1;
      end
    end
    if (inject_req != inject_done) begin
      inject_done++;
      mul_fin = 1'b1;
      {mul_obusA, mul_obusB} = 64'hDEAD_BEEF_0BAD_F00D;
    end
    if (mul_fin) last_fin_cyc = cyc;
  endtask

  task automatic push_one(logic [W-1:0] a, logic [W-1:0] b);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    n        = 0;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 20);
    in_valid = 1'b0;
    check("push_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_bgn();
    int n;
    n = 0;
    while (!mul_bgn && n < 20) begin
      step();
      n++;
    end
    check("bgn_seen", 64'(mul_bgn), 64'd1);
  endtask

  task automatic run_vec(vec_t v);
    int k;
    fin_lat = v.lat;
    push_one(v.a, v.b);
    wait_bgn();
    check("ibusA", 64'(mul_ibusA), 64'(v.a));
    check("ibusB", 64'(mul_ibusB), 64'(v.b));
    step();
    check("bgn_one_cycle", 64'(mul_bgn), 64'd0);
    check("busy_wait", 64'(busy), 64'd1);
    k = 1;
    while (!out_valid && k < 300) begin
      step();
      k++;
    end
    check("fin_to_valid", 64'(k), 64'(v.lat + 1));
    check("vec_prod", out_prod, v.prod);
    repeat (6) step();
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  vec_t         vecs[7];
  logic [W-1:0] pa[4];
  logic [W-1:0] pb[4];

  initial begin
    int   n;
    int   acc_n;
    int   b0;
    int   o0;
    int   sent;
    logic acc;
    logic saw_valid;
    logic saw_not_ready;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    mul_fin = 1'b0; mul_obusA = '0; mul_obusB = '0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_prod", out_prod, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_bgn", 64'(mul_bgn), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_ibus", {mul_ibusA, mul_ibusB}, 64'd0);

    vecs[0] = '{32'd101,       32'd63,        3, 64'd6363};
    vecs[1] = '{32'hFFFF_FFF9, 32'd5,         1, 64'hFFFF_FFFF_FFFF_FFDD};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 4, 64'h4000_0000_0000_0000};
    vecs[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 2, 64'h3FFF_FFFF_0000_0001};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 64'd1};
    vecs[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 5, 64'hC000_0000_8000_0000};
    vecs[6] = '{32'd0,         32'd12345,     2, 64'd0};
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Four pairs against a stalled consumer: only the first job may issue.
    pa[0] = 32'd3;          pb[0] = 32'd4;
    pa[1] = 32'hFFFF_FFFE;  pb[1] = 32'd9;
    pa[2] = 32'd1000;       pb[2] = 32'd1000;
    pa[3] = 32'h7FFF_FFFF;  pb[3] = 32'd2;
    fin_lat = 5; out_ready = 1'b0; b0 = bgn_count; o0 = out_count; acc_n = 0;
    in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
    for (int i = 0; i < 300; i++) begin
      acc = in_ready;
      step();
      if (acc) begin
        acc_n++;
        if (acc_n < 4) begin in_a = pa[acc_n]; in_b = pb[acc_n]; end
        if (acc_n == 3) check("in_ready_drop", 64'(in_ready), 64'd0);
      end
    end
    check("stall_accepted", 64'(acc_n), 64'd3);
    check("stall_bgn", 64'(bgn_count - b0), 64'd1);
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_prod", out_prod, ref_mul(pa[0], pb[0]));
    out_ready = 1'b1;
    n = 0;
    while ((acc_n < 4 || exp_q.size() != 0 || busy || out_valid) && n < 300) begin
      acc = in_valid && in_ready;
      step();
      n++;
      if (acc) begin
        acc_n++;
        in_valid = 1'b0;
      end
    end
    check("stall_drained", 64'(out_count - o0), 64'd4);

    // Multiplier never finishes.
    model_en = 0;
    push_one(32'd11, 32'd13);
    wait_bgn();
    n = 0;
    while (!err && n < 400) begin
      step();
      n++;
    end
    check("timeout_cycles", 64'(n), 64'(TO + 1));
    check("halt_busy", 64'(busy), 64'd1);
    check("halt_in_ready", 64'(in_ready), 64'd0);
    b0 = bgn_count; saw_not_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'd2; in_b = 32'd2;
    repeat (20) begin
      if (in_ready) saw_not_ready = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("halt_no_accept", 64'(saw_not_ready), 64'd0);
    check("halt_no_bgn", 64'(bgn_count - b0), 64'd0);
    check("err_sticky", 64'(err), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rearm_err", 64'(err), 64'd0);
    check("rearm_in_ready", 64'(in_ready), 64'd1);
    check("rearm_busy", 64'(busy), 64'd0);

    // Reset mid-WAIT with a second pair queued, then a stray fin.
    push_one(32'd21, 32'd22);
    push_one(32'd31, 32'd32);
    wait_bgn();
    repeat (5) step();
    check("midwait_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    inject_req++;
    b0 = bgn_count; saw_valid = 1'b0; saw_not_ready = 1'b0;
    repeat (30) begin
      step();
      if (out_valid) saw_valid = 1'b1;
      if (!in_ready) saw_not_ready = 1'b1;
    end
    check("late_fin_valid", 64'(saw_valid), 64'd0);
    check("late_fin_bgn", 64'(bgn_count - b0), 64'd0);
    check("late_fin_ready", 64'(saw_not_ready), 64'd0);
    check("late_fin_ibus", {mul_ibusA, mul_ibusB}, 64'd0);
    check("late_fin_busy", 64'(busy), 64'd0);

    // Random traffic with random multiplier latency and consumer stalls.
    model_en = 1; lat_rand = 1; o0 = out_count; sent = 0; n = 0;
    while (sent < 40 && n < 5000) begin
      acc = in_valid && in_ready;
      step();
      n++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      if (!in_valid && sent < 40 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        in_b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || busy) && n < 500) begin
      step();
      n++;
    end
    check("rand_sent", 64'(sent), 64'd40);
    check("rand_drained", 64'(out_count - o0), 64'd40);
    check("rand_err", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
